// File: rtl/hypot_pkg.sv
// Shared definitions for the hypot_unit magnitude coprocessor.
// Latency: n/a (types, op codes and width helpers only).
// Backpressure: n/a.
package hypot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQ_A    = 3'd1,
    SQ_B    = 3'd2,
    COMBINE = 3'd3,
    ROOT    = 3'd4
  } state_e;

  localparam logic OP_SUM  = 1'b0;
  localparam logic OP_DIFF = 1'b1;

  // Width of a full W x W square.
  function automatic int sq_width(input int w);
    return 2 * w;
  endfunction

  // Radicand width handed to the root engine; even so it splits into bit pairs.
  function automatic int rad_width(input int w);
    return 2 * w + 2;
  endfunction

  // Counter width for the W-cycle squaring passes.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Restoring digit-by-digit integer square root of an NW-bit radicand.
// Latency: NW/2 cycles after the start edge; done_o is high on the final iteration cycle.
// Backpressure: start_i is ignored while busy_o is high; results hold until the next finish.
module isqrt_seq #(
  parameter int NW = 18
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [NW-1:0]   rad_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [NW/2-1:0] root_o,
  output logic [NW/2:0]   rem_o
);
  localparam int HW = NW / 2;
  localparam int CW = $clog2(HW);
  localparam logic [CW-1:0] LAST = CW'(HW - 1);

  logic [NW-1:0] r_x;
  logic [HW-1:0] r_q;
  logic [HW:0]   r_r;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [HW+2:0] w_r_sh;
  logic [HW+2:0] w_trial;
  logic          w_ge;
  logic [HW:0]   w_r_nxt;
  logic [HW-1:0] w_q_nxt;

  // Bring down the next bit pair and try subtracting 4q+1.
  assign w_r_sh  = {r_r, r_x[NW-1 -: 2]};
  assign w_trial = {1'b0, r_q, 2'b01};
  assign w_ge    = (w_r_sh >= w_trial);
  // Remainder never exceeds 2q, so it always fits back into HW+1 bits.
  assign w_r_nxt = w_ge ? (HW+1)'(w_r_sh - w_trial) : (HW+1)'(w_r_sh);
  assign w_q_nxt = (r_q << 1) | {{(HW-1){1'b0}}, w_ge};

  assign busy_o = r_busy;
  assign done_o = r_busy && (r_cnt == LAST);

  // Iterate one root bit per cycle; outputs update only on the last iteration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x    <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      root_o <= '0;
      rem_o  <= '0;
    end else if (start_i && !r_busy) begin
      r_x    <= rad_i;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_x   <= r_x << 2;
      r_q   <= w_q_nxt;
      r_r   <= w_r_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        root_o <= w_q_nxt;
        rem_o  <= w_r_nxt;
      end
    end
  end

endmodule

// File: rtl/hypot_unit.sv
// Sequential floor(sqrt(a^2+b^2)) / floor(sqrt(|a^2-b^2|)) with remainder.
// Latency: valid_o rises 3W+2 edges after the accept edge.
// Backpressure: one op in flight; start_i ignored while busy_o, accepted again in the valid cycle.
module hypot_unit
  import hypot_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] a_bi,
  input  logic [W-1:0] b_bi,
  input  logic         op_i,
  input  logic         start_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         valid_o,
  output logic [W:0]   y_bo,
  output logic [W+1:0] rem_bo
);
  localparam int SQW  = sq_width(W);
  localparam int RADW = rad_width(W);
  localparam int CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e         r_state;
  logic [W-1:0]   r_b;
  logic           r_op;
  logic [SQW-1:0] r_acc;
  logic [SQW-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic [SQW-1:0] r_sqa;
  logic [SQW-1:0] r_sqb;
  logic           r_valid;

  logic [SQW-1:0]  w_acc_nxt;
  logic [SQW:0]    w_sum;
  logic [SQW-1:0]  w_diff;
  logic [RADW-1:0] w_rad;
  logic            w_root_start;
  logic            w_root_busy;
  logic            w_root_done;

  // One partial product per cycle: add the shifted multiplicand when the low multiplier bit is set.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Compare-then-subtract keeps the difference unsigned without a sign bit.
  assign w_sum  = {1'b0, r_sqa} + {1'b0, r_sqb};
  assign w_diff = (r_sqa >= r_sqb) ? (r_sqa - r_sqb) : (r_sqb - r_sqa);
  assign w_rad  = (r_op == OP_SUM) ? {1'b0, w_sum} : {2'b00, w_diff};

  assign w_root_start = (r_state == COMBINE);

  assign busy_o  = (r_state != IDLE) || w_root_busy;
  assign ready_o = !busy_o;
  assign valid_o = r_valid;

  isqrt_seq #(
    .NW(RADW)
  ) u_isqrt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(w_root_start),
    .rad_i  (w_rad),
    .busy_o (w_root_busy),
    .done_o (w_root_done),
    .root_o (y_bo),
    .rem_o  (rem_bo)
  );

  // Control FSM plus the shared shift-add squarer, reused for a then b.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_b      <= '0;
      r_op     <= OP_SUM;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sqa    <= '0;
      r_sqb    <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_b      <= b_bi;
            r_op     <= op_i;
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, a_bi};
            r_mplier <= a_bi;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_state  <= SQ_A;
          end
        end
        SQ_A, SQ_B: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, r_b};
            r_mplier <= r_b;
            r_cnt    <= '0;
            if (r_state == SQ_A) begin
              r_sqa   <= w_acc_nxt;
              r_state <= SQ_B;
            end else begin
              r_sqb   <= w_acc_nxt;
              r_state <= COMBINE;
            end
          end
        end
        COMBINE: begin
          r_state <= ROOT;
        end
        ROOT: begin
          if (w_root_done) begin
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_unit.sv
// Directed bench for hypot_unit: W=8 instance for most scenarios, W=16 for the wide case.
// Latency: checks valid_o at 3W+2 edges after accept.
// Backpressure: exercises held start, back-to-back accept and async reset mid-operation.
module tb_hypot_unit;

  logic        clk;
  logic        rst_n;

  logic [7:0]  a8, b8;
  logic        op8, start8;
  logic        ready8, busy8, valid8;
  logic [8:0]  y8;
  logic [9:0]  rem8;

  logic [15:0] a16, b16;
  logic        op16, start16;
  logic        ready16, busy16, valid16;
  logic [16:0] y16;
  logic [17:0] rem16;

  int checks;
  int errors;

  hypot_unit #(.W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .a_bi(a8), .b_bi(b8), .op_i(op8), .start_i(start8),
    .ready_o(ready8), .busy_o(busy8), .valid_o(valid8), .y_bo(y8), .rem_bo(rem8)
  );

  hypot_unit #(.W(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .a_bi(a16), .b_bi(b16), .op_i(op16), .start_i(start16),
    .ready_o(ready16), .busy_o(busy16), .valid_o(valid16), .y_bo(y16), .rem_bo(rem16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands and hold start for exactly one accept edge; returns 1 ns after that edge.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic op);
    a8 = a; b8 = b; op8 = op; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Count edges until valid8 is seen; n = -1 if the budget runs out.
  task automatic wait8(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (valid8) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a8 = '0; b8 = '0; op8 = 1'b0; start8 = 1'b0;
    a16 = '0; b16 = '0; op16 = 1'b0; start16 = 1'b0;
    #12;
    checks++; if (y8 !== 9'd0) begin errors++; $display("FAIL reset_y8: got %0d expected 0", y8); end
    checks++; if (rem8 !== 10'd0) begin errors++; $display("FAIL reset_rem8: got %0d expected 0", rem8); end
    checks++; if (valid8 !== 1'b0 || busy8 !== 1'b0 || ready8 !== 1'b1) begin
      errors++; $display("FAIL reset_flags8: got v=%b b=%b r=%b expected v=0 b=0 r=1", valid8, busy8, ready8); end
    checks++; if (y16 !== 17'd0 || rem16 !== 18'd0 || valid16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++; $display("FAIL reset_16: got y=%0d rem=%0d v=%b b=%b expected all 0", y16, rem16, valid16, busy16); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sum_basic();
    int n;
    accept8(8'd3, 8'd4, 1'b0);
    checks++; if (busy8 !== 1'b1 || ready8 !== 1'b0 || valid8 !== 1'b0) begin
      errors++; $display("FAIL basic_after_accept: got b=%b r=%b v=%b expected b=1 r=0 v=0", busy8, ready8, valid8); end
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 25) begin
        checks++; if (busy8 !== 1'b1 || valid8 !== 1'b0) begin
          errors++; $display("FAIL basic_edge25: got b=%b v=%b expected b=1 v=0", busy8, valid8); end
      end
      if (valid8) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 26) begin errors++; $display("FAIL basic_latency: got %0d expected 26", n); end
    checks++; if (y8 !== 9'd5 || rem8 !== 10'd0) begin
      errors++; $display("FAIL basic_result: got y=%0d rem=%0d expected y=5 rem=0", y8, rem8); end
    checks++; if (busy8 !== 1'b0 || ready8 !== 1'b1) begin
      errors++; $display("FAIL basic_done_flags: got b=%b r=%b expected b=0 r=1", busy8, ready8); end
  endtask

  task automatic test_sum_max();
    int n;
    accept8(8'd255, 8'd255, 1'b0);
    wait8(n);
    checks++; if (n !== 26) begin errors++; $display("FAIL max_latency: got %0d expected 26", n); end
    checks++; if (y8 !== 9'd360 || rem8 !== 10'd450) begin
      errors++; $display("FAIL max_result: got y=%0d rem=%0d expected y=360 rem=450", y8, rem8); end
  endtask

  task automatic test_back_to_back();
    int n;
    accept8(8'd5, 8'd3, 1'b1);
    wait8(n);
    checks++; if (n !== 26) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 26", n); end
    checks++; if (y8 !== 9'd4 || rem8 !== 10'd0) begin
      errors++; $display("FAIL b2b_first_result: got y=%0d rem=%0d expected y=4 rem=0", y8, rem8); end
    // Start again while valid is still high.
    accept8(8'd3, 8'd5, 1'b1);
    checks++; if (valid8 !== 1'b0 || busy8 !== 1'b1) begin
      errors++; $display("FAIL b2b_reaccept: got v=%b b=%b expected v=0 b=1", valid8, busy8); end
    checks++; if (y8 !== 9'd4) begin errors++; $display("FAIL b2b_hold_y: got %0d expected 4", y8); end
    wait8(n);
    checks++; if (n !== 26) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 26", n); end
    checks++; if (y8 !== 9'd4 || rem8 !== 10'd0) begin
      errors++; $display("FAIL b2b_second_result: got y=%0d rem=%0d expected y=4 rem=0", y8, rem8); end
  endtask

  task automatic test_held_start();
    int n;
    a8 = 8'd7; b8 = 8'd9; op8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    // Keep start high and scramble the inputs while busy.
    a8 = 8'd1; b8 = 8'd2; op8 = 1'b1;
    wait8(n);
    start8 = 1'b0;
    checks++; if (n !== 26) begin errors++; $display("FAIL held_latency: got %0d expected 26", n); end
    checks++; if (y8 !== 9'd11 || rem8 !== 10'd9) begin
      errors++; $display("FAIL held_result: got y=%0d rem=%0d expected y=11 rem=9", y8, rem8); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++; $display("FAIL held_single_accept: got v=%b b=%b expected v=1 b=0", valid8, busy8); end
  endtask

  task automatic test_reset_mid();
    int n;
    accept8(8'd10, 8'd20, 1'b0);
    repeat (11) @(posedge clk);
    checks++; if (y8 !== 9'd11 || busy8 !== 1'b1) begin
      errors++; $display("FAIL mid_hold_before_reset: got y=%0d b=%b expected y=11 b=1", y8, busy8); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (y8 !== 9'd0 || rem8 !== 10'd0 || valid8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL mid_async_reset: got y=%0d rem=%0d v=%b b=%b expected all 0", y8, rem8, valid8, busy8); end
    #4 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL mid_no_spurious: got v=%b b=%b expected v=0 b=0", valid8, busy8); end
    accept8(8'd6, 8'd8, 1'b0);
    wait8(n);
    checks++; if (n !== 26) begin errors++; $display("FAIL mid_after_latency: got %0d expected 26", n); end
    checks++; if (y8 !== 9'd10 || rem8 !== 10'd0) begin
      errors++; $display("FAIL mid_after_result: got y=%0d rem=%0d expected y=10 rem=0", y8, rem8); end
  endtask

  task automatic test_wide();
    int n;
    a16 = 16'd65535; b16 = 16'd0; op16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (valid16) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 50) begin errors++; $display("FAIL w16_latency: got %0d expected 50", n); end
    checks++; if (y16 !== 17'd65535 || rem16 !== 18'd0) begin
      errors++; $display("FAIL w16_result: got y=%0d rem=%0d expected y=65535 rem=0", y16, rem16); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sum_basic();
    test_sum_max();
    test_back_to_back();
    test_held_start();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
